// File: rtl/output_port.sv
// Router output-port link controller: registers crossbar flits onto the link and tracks
// per-VC downstream occupancy (IDLE/RESERVED/ACTIVE/DRAIN) plus registered on/off flow control.
package noc_params;
    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = 3;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        logic [DATA_W-1:0]    data;
    } flit_t;
endpackage

module output_port
    import noc_params::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              flit_i,
    input  logic               valid_i,
    input  logic [VC_NUM-1:0]  vc_reserve_i,
    input  logic [VC_NUM-1:0]  on_off_i,
    input  logic [VC_NUM-1:0]  vc_allocatable_i,
    output flit_t              data_o,
    output logic               valid_flit_o,
    output logic [VC_NUM-1:0]  vc_available_o,
    output logic [VC_NUM-1:0]  vc_ready_o,
    output logic               error_o
);
    localparam int CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam int VC_IDX_W = $clog2(VC_NUM);
    localparam logic [VC_SIZE-1:0] VC_LIMIT = VC_SIZE'(VC_NUM);

    typedef enum logic [1:0] {IDLE, RESERVED, ACTIVE, DRAIN} vc_state_t;

    vc_state_t         r_state [VC_NUM];
    logic [CNT_W-1:0]  r_cnt   [VC_NUM];
    logic [VC_NUM-1:0] r_on_q;

    logic                w_id_ok;
    logic [VC_IDX_W-1:0] w_vc;
    logic                w_accept;
    logic                w_flit_err;
    logic                w_res_err;
    vc_state_t           w_flit_next;

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            vc_ready_o[v]     = ((r_state[v] == RESERVED) || (r_state[v] == ACTIVE)) && r_on_q[v];
            vc_available_o[v] = (r_state[v] == IDLE);
        end
    end

    assign w_id_ok   = (flit_i.vc_id < VC_LIMIT);
    assign w_vc      = flit_i.vc_id[VC_IDX_W-1:0];
    // A reserve is only legal against a VC that is IDLE before this edge.
    assign w_res_err = |(vc_reserve_i & ~vc_available_o);

    always_comb begin
        w_accept    = 1'b0;
        w_flit_err  = 1'b0;
        w_flit_next = IDLE;
        if (valid_i) begin
            if (!w_id_ok || !vc_ready_o[w_vc]) begin
                w_flit_err = 1'b1;
            end else begin
                case (r_state[w_vc])
                    RESERVED: begin
                        if (flit_i.flit_label == HEAD) begin
                            w_accept    = 1'b1;
                            w_flit_next = ACTIVE;
                        end else if (flit_i.flit_label == HEADTAIL) begin
                            w_accept    = 1'b1;
                            w_flit_next = DRAIN;
                        end else begin
                            w_flit_err = 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (flit_i.flit_label == BODY) begin
                            w_accept    = 1'b1;
                            w_flit_next = ACTIVE;
                        end else if (flit_i.flit_label == TAIL) begin
                            w_accept    = 1'b1;
                            w_flit_next = DRAIN;
                        end else begin
                            w_flit_err = 1'b1;
                        end
                    end
                    default: w_flit_err = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_state[v] <= IDLE;
                r_cnt[v]   <= '0;
            end
            r_on_q       <= '0;
            data_o       <= '0;
            valid_flit_o <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            r_on_q       <= on_off_i;
            valid_flit_o <= w_accept;
            if (w_accept) begin
                data_o <= flit_i;
            end
            if (w_flit_err || w_res_err) begin
                error_o <= 1'b1;
            end
            for (int v = 0; v < VC_NUM; v++) begin
                case (r_state[v])
                    IDLE: begin
                        if (vc_reserve_i[v]) begin
                            r_state[v] <= RESERVED;
                        end
                    end
                    RESERVED, ACTIVE: begin
                        if (w_accept && (w_vc == VC_IDX_W'(v))) begin
                            r_state[v] <= w_flit_next;
                            if (w_flit_next == DRAIN) begin
                                r_cnt[v] <= CNT_W'(DRAIN_CYCLES);
                            end
                        end
                    end
                    default: begin
                        // Hold off until the downstream allocatable bit is no longer stale.
                        if (r_cnt[v] != '0) begin
                            r_cnt[v] <= r_cnt[v] - 1'b1;
                        end else if (vc_allocatable_i[v]) begin
                            r_state[v] <= IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_output_port.sv
// Bench for output_port: directed scenarios plus random traffic checked every cycle
// against a packet-level occupancy model.
module tb_output_port;
    import noc_params::*;

    localparam int D = 2;
    localparam int FREE = 0, OWNED = 1, INPKT = 2, DRAINING = 3;

    logic              clk = 1'b0;
    logic              rst;
    flit_t             flit_i;
    logic              valid_i;
    logic [VC_NUM-1:0] vc_reserve_i, on_off_i, vc_allocatable_i;
    flit_t             data_o;
    logic              valid_flit_o;
    logic [VC_NUM-1:0] vc_available_o, vc_ready_o;
    logic              error_o;

    output_port #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i),
        .vc_reserve_i(vc_reserve_i), .on_off_i(on_off_i),
        .vc_allocatable_i(vc_allocatable_i), .data_o(data_o),
        .valid_flit_o(valid_flit_o), .vc_available_o(vc_available_o),
        .vc_ready_o(vc_ready_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int    m_ph   [VC_NUM];
    int    m_left [VC_NUM];
    bit    m_on   [VC_NUM];
    bit    m_err, m_vld;
    flit_t m_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            m_ph[v] = FREE; m_left[v] = 0; m_on[v] = 1'b0;
        end
        m_err = 1'b0; m_vld = 1'b0; m_dat = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  oph [VC_NUM];
        bit  rdy [VC_NUM];
        int  id;
        bit  acc;
        for (int v = 0; v < VC_NUM; v++) begin
            oph[v] = m_ph[v];
            rdy[v] = ((oph[v] == OWNED) || (oph[v] == INPKT)) && m_on[v];
        end
        for (int v = 0; v < VC_NUM; v++) begin
            if (oph[v] == DRAINING) begin
                if (m_left[v] > 0) m_left[v]--;
                else if (vc_allocatable_i[v]) m_ph[v] = FREE;
            end
            if (vc_reserve_i[v]) begin
                if (oph[v] == FREE) m_ph[v] = OWNED;
                else m_err = 1'b1;
            end
        end
        acc = 1'b0;
        if (valid_i) begin
            id = int'(flit_i.vc_id);
            if (id >= VC_NUM) m_err = 1'b1;
            else if (!rdy[id]) m_err = 1'b1;
            else if (oph[id] == OWNED && flit_i.flit_label == HEAD) begin
                m_ph[id] = INPKT; acc = 1'b1;
            end else if (oph[id] == OWNED && flit_i.flit_label == HEADTAIL) begin
                m_ph[id] = DRAINING; m_left[id] = D; acc = 1'b1;
            end else if (oph[id] == INPKT && flit_i.flit_label == BODY) begin
                acc = 1'b1;
            end else if (oph[id] == INPKT && flit_i.flit_label == TAIL) begin
                m_ph[id] = DRAINING; m_left[id] = D; acc = 1'b1;
            end else m_err = 1'b1;
        end
        m_vld = acc;
        if (acc) m_dat = flit_i;
        for (int v = 0; v < VC_NUM; v++) m_on[v] = on_off_i[v];
    endtask

    task automatic compare_all();
        logic [VC_NUM-1:0] ea, er;
        for (int v = 0; v < VC_NUM; v++) begin
            ea[v] = (m_ph[v] == FREE);
            er[v] = ((m_ph[v] == OWNED) || (m_ph[v] == INPKT)) && m_on[v];
        end
        chk("valid_flit_o", 64'(valid_flit_o), 64'(m_vld));
        chk("data_o", 64'(data_o), 64'(m_dat));
        chk("error_o", 64'(error_o), 64'(m_err));
        chk("vc_available_o", 64'(vc_available_o), 64'(ea));
        chk("vc_ready_o", 64'(vc_ready_o), 64'(er));
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0; vc_reserve_i = '0;
        repeat (n) step();
    endtask

    task automatic reserve(input logic [VC_NUM-1:0] mask);
        valid_i = 1'b0; vc_reserve_i = mask;
        step();
        vc_reserve_i = '0;
    endtask

    task automatic send(input int vc, input flit_label_t l, input logic [15:0] d);
        valid_i = 1'b1; vc_reserve_i = '0;
        flit_i.flit_label = l; flit_i.vc_id = VC_SIZE'(vc); flit_i.data = d;
        step();
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        valid_i = 1'b0; vc_reserve_i = '0;
        rst = 1'b1; model_reset();
        #1 compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    int          seq_vc  [6] = '{0, 3, 0, 3, 0, 3};
    flit_label_t seq_lbl [6] = '{HEAD, HEAD, BODY, BODY, TAIL, TAIL};

    initial begin
        rst = 1'b1; valid_i = 1'b0; flit_i = '0; vc_reserve_i = '0;
        on_off_i = '1; vc_allocatable_i = '1;
        model_reset();
        @(negedge clk);
        compare_all();
        chk("reset avail", 64'(vc_available_o), 64'(4'hF));
        chk("reset ready", 64'(vc_ready_o), 64'(4'h0));
        chk("reset valid", 64'(valid_flit_o), 64'(1'b0));
        rst = 1'b0;

        // Single packet on VC0
        idle(1);
        reserve(4'b0001);
        chk("pkt avail0 after reserve", 64'(vc_available_o[0]), 64'(1'b0));
        chk("pkt ready0 after reserve", 64'(vc_ready_o[0]), 64'(1'b1));
        send(0, HEAD, 16'hA001);
        chk("pkt head data", 64'(data_o.data), 64'(16'hA001));
        send(0, BODY, 16'hA002);
        chk("pkt body data", 64'(data_o.data), 64'(16'hA002));
        send(0, TAIL, 16'hA003);
        chk("pkt tail data", 64'(data_o.data), 64'(16'hA003));
        chk("pkt tail valid", 64'(valid_flit_o), 64'(1'b1));
        idle(1); chk("drain t+1 avail0", 64'(vc_available_o[0]), 64'(1'b0));
        idle(1); chk("drain t+2 avail0", 64'(vc_available_o[0]), 64'(1'b0));
        idle(1); chk("drain t+3 avail0", 64'(vc_available_o[0]), 64'(1'b1));
        chk("pkt error", 64'(error_o), 64'(1'b0));

        // HEADTAIL on VC1, downstream not yet allocatable
        reserve(4'b0010);
        vc_allocatable_i[1] = 1'b0;
        send(1, HEADTAIL, 16'hB001);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("headtail held avail1", 64'(vc_available_o[1]), 64'(1'b0));
        end
        vc_allocatable_i[1] = 1'b1;
        idle(1);
        chk("headtail released avail1", 64'(vc_available_o[1]), 64'(1'b1));

        // Backpressure on VC0
        reserve(4'b0001);
        send(0, HEAD, 16'hC001);
        on_off_i[0] = 1'b0;
        idle(1);
        chk("bp ready0 off", 64'(vc_ready_o[0]), 64'(1'b0));
        send(0, BODY, 16'hC002);
        chk("bp dropped valid", 64'(valid_flit_o), 64'(1'b0));
        chk("bp error", 64'(error_o), 64'(1'b1));
        on_off_i[0] = 1'b1;
        idle(1);
        chk("bp ready0 on", 64'(vc_ready_o[0]), 64'(1'b1));
        send(0, BODY, 16'hC003);
        send(0, TAIL, 16'hC004);
        chk("bp tail data", 64'(data_o.data), 64'(16'hC004));
        idle(4);
        chk("bp done avail0", 64'(vc_available_o[0]), 64'(1'b1));
        do_reset();
        idle(1);

        // Illegal sequences on VC2 / VC3 / out-of-range id
        reserve(4'b0100);
        send(2, BODY, 16'hE001);
        chk("ill body valid", 64'(valid_flit_o), 64'(1'b0));
        chk("ill body error", 64'(error_o), 64'(1'b1));
        chk("ill body still reserved", 64'(vc_ready_o[2]), 64'(1'b1));
        send(2, HEAD, 16'hE002);
        reserve(4'b0100);
        send(2, TAIL, 16'hE003);
        chk("ill active kept", 64'(valid_flit_o), 64'(1'b1));
        send(3, HEAD, 16'hE004);
        chk("ill idle flit avail3", 64'(vc_available_o[3]), 64'(1'b1));
        send(5, HEAD, 16'hE005);
        chk("ill sticky error", 64'(error_o), 64'(1'b1));
        idle(4);
        do_reset();
        idle(1);

        // Interleaved packets on VC0 and VC3
        reserve(4'b1001);
        for (int i = 0; i < 6; i++) begin
            send(seq_vc[i], seq_lbl[i], 16'(16'hD000 + i));
            chk("interleave vc order", 64'(data_o.vc_id), 64'(seq_vc[i]));
        end
        idle(4);
        chk("interleave avail", 64'(vc_available_o), 64'(4'hF));
        chk("interleave error", 64'(error_o), 64'(1'b0));

        // Asynchronous reset with VC2 active
        reserve(4'b0100);
        send(2, HEAD, 16'hF001);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async avail", 64'(vc_available_o), 64'(4'hF));
        chk("async ready", 64'(vc_ready_o), 64'(4'h0));
        chk("async valid", 64'(valid_flit_o), 64'(1'b0));
        chk("async data", 64'(data_o), 64'(0));
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Random legal traffic
        for (int c = 0; c < 1500; c++) begin
            int v;
            vc_reserve_i = '0; valid_i = 1'b0;
            for (int k = 0; k < VC_NUM; k++) begin
                on_off_i[k]         = ($urandom_range(0, 7) != 0);
                vc_allocatable_i[k] = ($urandom_range(0, 3) != 0);
                if (m_ph[k] == FREE && $urandom_range(0, 3) == 0) vc_reserve_i[k] = 1'b1;
            end
            v = $urandom_range(0, VC_NUM - 1);
            if ((m_ph[v] == OWNED || m_ph[v] == INPKT) && m_on[v] && $urandom_range(0, 3) != 0) begin
                valid_i = 1'b1;
                flit_i.vc_id = VC_SIZE'(v);
                flit_i.data  = 16'($urandom);
                if (m_ph[v] == OWNED) flit_i.flit_label = ($urandom_range(0, 2) == 0) ? HEADTAIL : HEAD;
                else flit_i.flit_label = ($urandom_range(0, 2) == 0) ? TAIL : BODY;
            end
            step();
        end
        chk("random legal error", 64'(error_o), 64'(1'b0));

        // Random unconstrained traffic
        for (int c = 0; c < 1200; c++) begin
            if (c % 200 == 0) do_reset();
            for (int k = 0; k < VC_NUM; k++) begin
                vc_reserve_i[k]     = ($urandom_range(0, 7) == 0);
                on_off_i[k]         = ($urandom_range(0, 5) != 0);
                vc_allocatable_i[k] = ($urandom_range(0, 2) != 0);
            end
            valid_i = ($urandom_range(0, 1) == 1);
            flit_i.vc_id      = VC_SIZE'($urandom_range(0, 7));
            flit_i.flit_label = flit_label_t'($urandom_range(0, 3));
            flit_i.data       = 16'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/output_port.md
# output_port

Output-side link controller for one router output port, at the transmitting end of the flit/on-off/vc-allocatable link that the downstream router's input block terminates. It takes flits from the crossbar and registers them onto the link (`data_o`/`valid_flit_o`). It also tracks the occupancy of each downstream VC from VA reservation to drain confirmation. It registers the downstream on/off flow-control bits and exposes per-VC availability to the VC allocator and per-VC send readiness to the switch allocator. One instance is used per output port.

## Interface
- `VC_NUM`: taken from `noc_params`; the number of virtual channels per port.
- `DRAIN_CYCLES`, default 2: the minimum number of cycles after a tail is launched before the VC may be freed. This masks the stale downstream `vc_allocatable` value. Legal range is 1 or greater.

- `clk`  in  1  the single clock for the block.
- `rst`  in  1  reset, asynchronous and active-high.
- `flit_i`  in  flit_t  the flit from the crossbar. `flit_i.vc_id` selects the downstream VC.
- `valid_i`  in  1  `flit_i` is valid this cycle.
- `vc_reserve_i`  in  VC_NUM  a one-hot-per-bit VA grant. It claims a downstream VC for a new packet.
- `on_off_i`  in  VC_NUM  the downstream on/off flow-control bits. 1 means the VC may receive.
- `vc_allocatable_i`  in  VC_NUM  the downstream report that the VC buffer is empty and free.
- `data_o`  out  flit_t  the registered flit driven onto the link.
- `valid_flit_o`  out  1  `data_o` is valid.
- `vc_available_o`  out  VC_NUM  the VC is IDLE and may be granted by VA.
- `vc_ready_o`  out  VC_NUM  the VC may accept a flit this cycle. This output goes to the SA.
- `error_o`  out  1  a sticky protocol-violation flag. It clears only on `rst`.

## Operation
Each VC v has its own state register and a drain counter `cnt[v]` of width $clog2(DRAIN_CYCLES+1). The per-VC states are IDLE, RESERVED, ACTIVE and DRAIN.

- **IDLE**
  - On `vc_reserve_i[v]`, go to RESERVED.
- **RESERVED**
  - On an accepted HEAD, go to ACTIVE.
  - On an accepted HEADTAIL, go to DRAIN.
- **ACTIVE**
  - On an accepted BODY, stay in ACTIVE.
  - On an accepted TAIL, go to DRAIN.
- **DRAIN**
  - On entry, load `cnt[v]` = DRAIN_CYCLES.
  - Decrement `cnt[v]` each cycle while it is nonzero.
  - When `cnt[v]`==0 and `vc_allocatable_i[v]`==1, go to IDLE.

Flow control and output derivation:
- `on_q[v]` is `on_off_i[v]` registered.
- `vc_ready_o[v]` = (state is RESERVED or ACTIVE) && `on_q[v]`. It is combinational from registers.
- `vc_available_o[v]` = (state == IDLE).

A flit is accepted when `valid_i` is high, `vc_ready_o[flit_i.vc_id]` is high, and the flit label is legal for the current state. An accepted flit is copied to `data_o` at the next edge with `valid_flit_o`=1. Otherwise `valid_flit_o`=0 and `data_o` holds its value.

Each of the following is a violation. For every violation, `error_o` is set, the offending event is ignored, and no state changes:
- `valid_i` for a VC whose `vc_ready_o` is 0. This includes IDLE and DRAIN VCs, and on_q=0.
- A BODY or TAIL flit in RESERVED.
- A HEAD or HEADTAIL flit in ACTIVE.
- `vc_reserve_i[v]` for a VC that is not IDLE.
- A `flit_i.vc_id` >= VC_NUM.

Simultaneous events:
- `vc_reserve_i[v]` and a flit for v in the same cycle while v is IDLE: the reserve takes effect and the flit is a violation.
- A DRAIN→IDLE transition and `vc_reserve_i[v]` in the same cycle: this is a violation, because the VC is not yet IDLE. The transition still happens.
- Different VCs update independently in the same cycle.

## Timing
- Reset (async, active-high) sets the following:
  - all states to IDLE and all `cnt` to 0;
  - `on_q` to 0, so `vc_ready_o` is 0;
  - `data_o` to '0 and `valid_flit_o` to 0;
  - `error_o` to 0;
  - `vc_available_o` to all ones.
- If reset is asserted mid-packet, all in-flight VC state is discarded immediately.
- The latency from `flit_i` to `data_o` is 1 cycle. The block can sustain one flit per cycle.
- `on_off_i[v]` falling at edge t makes `vc_ready_o[v]` fall after edge t+1. This is a one-cycle registration. The downstream on/off threshold must cover this delay plus the link latency.
- `vc_reserve_i` at cycle t causes `vc_available_o` to fall and `vc_ready_o` (if on_q=1) to rise after edge t.
- A tail accepted at cycle t puts the VC in DRAIN after edge t. The earliest return to IDLE, and `vc_available_o` high, is after edge t+DRAIN_CYCLES+1.

## Test plan
- Single packet on VC0 with on_off_i=all ones:
  - Stimulus: reserve VC0, then HEAD, BODY, TAIL on consecutive cycles, with vc_allocatable_i[0]=1.
  - Required response: the three flits appear on data_o one cycle later, back-to-back. vc_available_o[0] is 0 from the reserve until 3 cycles after the TAIL (DRAIN_CYCLES=2). error_o stays 0.
- HEADTAIL on VC1:
  - Stimulus: reserve VC1, then send a HEADTAIL.
  - Required response: VC1 goes directly to DRAIN. It returns to IDLE only after cnt reaches 0 and vc_allocatable_i[1]=1. If vc_allocatable_i[1] is held at 0 for 10 cycles, vc_available_o[1] stays 0 for those cycles.
- Backpressure:
  - Stimulus: drop on_off_i[0] mid-packet.
  - Required response: vc_ready_o[0] falls one cycle later. A flit sent while vc_ready_o[0]=0 is dropped and error_o is set to 1. Raising on_off_i again restores vc_ready_o after one cycle, and the packet completes.
- Illegal sequences:
  - Case (a): a BODY in RESERVED.
  - Case (b): reserve of a VC in ACTIVE.
  - Case (c): a flit to an IDLE VC.
  - Required response: each case is dropped or ignored, error_o is set and sticky, and no state change occurs.
- Interleaving:
  - Stimulus: alternate HEAD/BODY/TAIL flits between VC0 and VC3 every cycle.
  - Required response: the output order matches the input order, and both VCs complete independently.
- Asynchronous reset during VC2 ACTIVE:
  - Required response: all outputs return to their reset values immediately, without a clock edge. After reset, vc_available_o is all ones.
